// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch T0-T2 then per-class execute steps decoded from IR[31:27].
// Optional CONTROL_SEQUENCER_MEM_WAIT_EN adds Mem_ready and stretches Read/Write steps until ready.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RESET | held in reset, all strobes low, Run=0
// ST_T0    | fetch: PC to MAR, PC+1 into Z
// ST_T1    | fetch: Z to PC, memory read into MDR
// ST_T2    | fetch: MDR to IR
// ST_T3    | first execute step, decoded from the op in IR
// ST_T4    | second execute step
// ST_T5    | third execute step (last for R-type / immediate / ldi)
// ST_T6    | ld read, st data stage, branch conditional PC load
// ST_T7    | ld write-back, st memory write
// ST_HALT  | stopped; only Reset leaves this state
module control_sequencer #(
    parameter logic [4:0] ADD_OP = 5'b00011,
    parameter logic [4:0] AND_OP = 5'b00101,
    parameter logic [4:0] OR_OP  = 5'b00110
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Stop,
    input  logic [31:0] IR,
    input  logic        CON_FF,
`ifdef CONTROL_SEQUENCER_MEM_WAIT_EN
    input  logic        Mem_ready,
`endif
    output logic        PCout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        HIout,
    output logic        LOout,
    output logic        BAout,
    output logic        InPortout,
    output logic        Cout,
    output logic        MARin,
    output logic        Zin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic        OutPortin,
    output logic        CONin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  alu_op,
    output logic        Run
);

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_IN   = 5'b10101;
    localparam logic [4:0] OP_OUT  = 5'b10110;
    localparam logic [4:0] OP_MFHI = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_HALT = 5'b11010;

    typedef enum logic [3:0] {
        ST_RESET, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [4:0] op;
    logic       is_rtype;
    logic       is_imm;
    logic       is_ld;
    logic       is_ldi;
    logic       is_st;
    logic       is_br;
    logic       is_addr;
    logic       is_long;
    logic       mem_ok;
    logic       unused_ir;

    assign op        = IR[31:27];
    assign unused_ir = ^IR[26:0];

    assign is_rtype = (op >= 5'b00011) && (op <= 5'b01011);
    assign is_imm   = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
    assign is_ld    = (op == OP_LD);
    assign is_ldi   = (op == OP_LDI);
    assign is_st    = (op == OP_ST);
    assign is_br    = (op == OP_BR);
    assign is_addr  = is_ld || is_ldi || is_st;
    assign is_long  = is_rtype || is_imm || is_addr || is_br;

`ifdef CONTROL_SEQUENCER_MEM_WAIT_EN
    assign mem_ok = Mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RESET: state_nxt = ST_T0;
            ST_T0:    state_nxt = Stop ? ST_HALT : ST_T1;
            ST_T1:    if (mem_ok) state_nxt = ST_T2;
            ST_T2:    state_nxt = ST_T3;
            ST_T3: begin
                if (op == OP_HALT)  state_nxt = ST_HALT;
                else if (is_long)   state_nxt = ST_T4;
                else                state_nxt = ST_T0;
            end
            ST_T4:    state_nxt = ST_T5;
            ST_T5:    state_nxt = (is_ld || is_st || is_br) ? ST_T6 : ST_T0;
            // ld holds T6 on its read; st's read-free T6 always advances
            ST_T6: begin
                if (is_ld)      state_nxt = mem_ok ? ST_T7 : ST_T6;
                else if (is_st) state_nxt = ST_T7;
                else            state_nxt = ST_T0;
            end
            ST_T7:    if (!is_st || mem_ok) state_nxt = ST_T0;
            ST_HALT:  state_nxt = ST_HALT;
            default:  state_nxt = ST_RESET;
        endcase
    end

    always_comb begin
        PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; HIout = 1'b0;
        LOout = 1'b0; BAout = 1'b0; InPortout = 1'b0; Cout = 1'b0;
        MARin = 1'b0; Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0;
        HIin = 1'b0; LOin = 1'b0; OutPortin = 1'b0; CONin = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
        IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
        alu_op = 5'b00000;
        Run = (state != ST_RESET) && (state != ST_HALT);
        case (state)
            ST_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            end
            ST_T1: begin
                Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            end
            ST_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            ST_T3: begin
                if (is_rtype || is_imm) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (is_addr) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end else if (is_br) begin
                    Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
                end else if (op == OP_IN) begin
                    InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (op == OP_OUT) begin
                    Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1;
                end else if (op == OP_MFHI) begin
                    HIout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (op == OP_MFLO) begin
                    LOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
            end
            ST_T4: begin
                if (is_rtype) begin
                    Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op;
                end else if (is_imm || is_addr) begin
                    Cout = 1'b1; Zin = 1'b1;
                    if (op == OP_ANDI)     alu_op = AND_OP;
                    else if (op == OP_ORI) alu_op = OR_OP;
                    else                   alu_op = ADD_OP;
                end else if (is_br) begin
                    PCout = 1'b1; Yin = 1'b1;
                end
            end
            ST_T5: begin
                if (is_rtype || is_imm || is_ldi) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_ld || is_st) begin
                    Zlowout = 1'b1; MARin = 1'b1;
                end else if (is_br) begin
                    Cout = 1'b1; Zin = 1'b1; alu_op = ADD_OP;
                end
            end
            ST_T6: begin
                if (is_ld) begin
                    Read = 1'b1; MDRin = 1'b1;
                end else if (is_st) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end else if (is_br && CON_FF) begin
                    Zlowout = 1'b1; PCin = 1'b1;
                end
            end
            ST_T7: begin
                if (is_ld) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_st) begin
                    Write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
